tile_cov_walker: RTL
====================

// Module: tile_cov_walker
// PURPOSE
//  Downstream of the edge-function generator. Takes per-triangle edge
//  coefficients (A,B) and initial edge values E at a tile origin, then walks
//  the tile one row per cycle. Emits a TILE_W-bit coverage mask per row to the
//  fragment/quad stage through a valid/ready handshake.
// PARAMETERS
//  W       25  signed width of A, B, E_init; matches generator (INT_W+SUBPIX+1)
//  TILE_W   8  pixels per row; also the mask width
//  TILE_H   8  rows per tile
// PORTS
//  clk        in   1          clock
//  rst        in   1          async active-high reset
//  valid_in   in   1          triangle/tile descriptor valid
//  ready_in   out  1          walker can accept a descriptor
//  A0,A1,A2   in   W s        per-pixel x step of each edge function
//  B0,B1,B2   in   W s        per-row y step of each edge function
//  E0_init,E1_init,E2_init  in  W s  edge values at pixel (0,0); top-left bias already applied
//  row_valid  out  1          row_mask/row_y are valid
//  row_ready  in   1          consumer accepts the row
//  row_y      out  $clog2(TILE_H)  row index inside the tile
//  row_mask   out  TILE_W     bit c = pixel (c,row_y) covered
//  row_last   out  1          current row is TILE_H-1
//  tile_rejected out 1        one-cycle pulse: tile dropped (tied 0 without macro)
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE. ready_in=0 while rst is high, then 1
//    in IDLE. row_valid=0, row_y=0, row_mask=0, row_last=0, tile_rejected=0.
//  - FSM states:
//    - IDLE: ready_in=1. Accept on valid_in&&ready_in: latch A*, B*; row
//      accumulators R_k=E_k_init; y=0. Next state WALK.
//    - WALK: ready_in=0, row_valid=1. On row_valid&&row_ready: R_k+=B_k, y++.
//      If row_last, go to IDLE instead.
//  - Latency: accept at edge T gives row 0 valid in cycle T+1. One row per
//    cycle under continuous row_ready. One IDLE bubble between tiles.
//  - Mask: E_k(c)=R_k + c*A_k for c in 0..TILE_W-1. Shift-add, no multiplier
//    on the critical path. mask[c] = (E_0(c)>=0)&&(E_1(c)>=0)&&(E_2(c)>=0).
//    The comparison is inclusive; the tie-break is already in the bias.
//  - Widths: accumulators and E_k(c) are W+$clog2(max(TILE_W,TILE_H))+1 bits,
//    sign-extended. They never wrap for any legal W-bit input.
//  - Stall: while row_valid&&!row_ready, row_y, row_mask and row_last hold
//    bit-stable, and the accumulators do not advance.
//  - All-zero rows are emitted like any other row (without the macro).
//  - valid_in outside IDLE is ignored. The descriptor is not consumed.
//  - Reset mid-walk: the tile is abandoned and no further rows are emitted.
//    After release the walker starts from IDLE.
// CONFIGURATION
//  TILE_COV_EARLY_REJECT_EN
//  - Defined: at accept, evaluate each edge at the 4 tile corners
//    (0,0), (TILE_W-1,0), (0,TILE_H-1), (TILE_W-1,TILE_H-1).
//    - If any edge is <0 at all 4 corners, the tile cannot be covered.
//      tile_rejected pulses in cycle T+1, no rows are emitted, and the state
//      stays IDLE (ready_in=1 in T+1).
//    - Otherwise behaviour is identical to the undefined case.
//  - Undefined: no corner logic, tile_rejected tied 0, and every accepted tile
//    emits exactly TILE_H rows.
// STRUCTURE
//  - raster_pkg: W, TILE_W, TILE_H defaults; typedef edge_coef_t {A,B,E};
//    localparam ACC_W; state enum {IDLE,WALK}.
//  - Sub-module edge_row_eval (one edge). Inputs R, A. Output TILE_W
//    sign bits. Combinational. Instantiated 3x; its outputs are ANDed into
//    row_mask.
// TESTING (TILE_W=TILE_H=8, bit0=column 0)
//  1. Half-plane x>=3: A0=1,B0=0,E0=-3. Edges 1,2: A=B=0,E=100.
//     -> 8 rows, each row_mask=8'hF8, row_y=0..7, row_last only at y=7,
//        first row_valid one cycle after accept.
//  2. Half-plane y<=3: A0=0,B0=-1,E0=3, other edges as in 1.
//     -> rows 0-3 mask 8'hFF, rows 4-7 mask 8'h00.
//  3. Backpressure: test 1 with row_ready=0 for 5 cycles at y=2.
//     -> y=2, mask 8'hF8 held stable. The row is not skipped or duplicated.
//     -> ready_in stays 0 until the y=7 handshake.
//  4. Reject: E0=-100, A0=1, B0=1.
//     -> With macro: tile_rejected pulses, 0 rows, ready_in=1 next cycle.
//     -> Without macro: 8 rows of 8'h00.
//  5. Reset mid-walk: assert rst at y=4.
//     -> row_valid=0 immediately. After release a new tile starts at y=0.
//  6. Extremes: E0=2^(W-1)-1, A0=2^(W-1)-1, B0=2^(W-1)-1.
//     -> Column 7 of row 7 still covered (no wrap).

Source files
------------

// File: rtl/raster_pkg.sv
// raster_pkg
//   Shared configuration for the tile rasteriser slice.
//   - W       : signed width of the edge coefficients from the generator
//   - TILE_W  : pixels per row (also the coverage mask width)
//   - TILE_H  : rows per tile
//   - ACC_W   : width of row accumulators and per-pixel edge values. Sized so
//               that E + (TILE_H-1)*B + (TILE_W-1)*A can never wrap.
//   - Y_W     : width of the row index
//   Also provides the edge coefficient record, the walker state enum and a
//   sign-extension helper.
package raster_pkg;

  localparam int W        = 25;
  localparam int TILE_W   = 8;
  localparam int TILE_H   = 8;
  localparam int TILE_MAX = (TILE_W > TILE_H) ? TILE_W : TILE_H;
  localparam int ACC_W    = W + $clog2(TILE_MAX) + 1;
  localparam int Y_W      = (TILE_H > 1) ? $clog2(TILE_H) : 1;

  // One edge function: per-pixel x step, per-row y step, value at (0,0).
  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] e;
  } edge_coef_t;

  typedef enum logic {
    IDLE,
    WALK
  } walk_state_e;

  // Widen a W-bit two's complement coefficient to accumulator width.
  function automatic logic signed [ACC_W-1:0] sext(input logic [W-1:0] v);
    return {{(ACC_W - W){v[W-1]}}, v};
  endfunction

endpackage

// File: rtl/edge_row_eval.sv
// edge_row_eval
//   Evaluates one edge function across a whole tile row, combinationally.
//   For every column c it forms E(c) = R + c*A and reports its sign bit.
//   Ports:
//     r_i    in  ACC_W signed  edge value at column 0 of the current row
//     a_i    in  ACC_W signed  per-pixel x step of the edge
//     neg_o  out TILE_W        bit c set when E(c) < 0
module edge_row_eval
  import raster_pkg::*;
(
  input  logic signed [ACC_W-1:0] r_i,
  input  logic signed [ACC_W-1:0] a_i,
  output logic [TILE_W-1:0]       neg_o
);

  localparam int CW = (TILE_W > 1) ? $clog2(TILE_W) : 1;

  logic signed [ACC_W-1:0] sum;

  // c*A is built from shifted copies of A selected by the bits of the
  // constant column index, so each column is a short adder tree rather than
  // a multiplier or a long ripple chain through the neighbouring columns.
  always_comb begin
    neg_o = '0;
    sum   = '0;
    for (int c = 0; c < TILE_W; c++) begin
      sum = r_i;
      for (int b = 0; b < CW; b++) begin
        if (((c >> b) & 1) == 1) begin
          sum = sum + (a_i <<< b);
        end
      end
      neg_o[c] = sum[ACC_W-1];
    end
  end

endmodule

// File: rtl/tile_cov_walker.sv
// tile_cov_walker
//   Accepts a triangle/tile descriptor (three edge functions) and walks the
//   tile one row per cycle, emitting a TILE_W-bit coverage mask per row over
//   a valid/ready handshake. Geometry comes from raster_pkg.
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     valid_in / ready_in      descriptor handshake (ready only in IDLE)
//     A0..A2, B0..B2           per-pixel x step / per-row y step, W-bit signed
//     E0_init..E2_init         edge values at pixel (0,0), bias already applied
//     row_valid / row_ready    row handshake
//     row_y                    row index inside the tile
//     row_mask                 bit c = pixel (c,row_y) covered
//     row_last                 current row is TILE_H-1
//     tile_rejected            one-cycle pulse when a tile is dropped
//   Optional feature macro: TILE_COV_EARLY_REJECT_EN
//     When defined, a tile whose corners are all outside some edge is dropped
//     at accept time. When undefined tile_rejected is tied low.
module tile_cov_walker
  import raster_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_in,
  output logic                ready_in,
  input  logic signed [W-1:0] A0,
  input  logic signed [W-1:0] A1,
  input  logic signed [W-1:0] A2,
  input  logic signed [W-1:0] B0,
  input  logic signed [W-1:0] B1,
  input  logic signed [W-1:0] B2,
  input  logic signed [W-1:0] E0_init,
  input  logic signed [W-1:0] E1_init,
  input  logic signed [W-1:0] E2_init,
  output logic                row_valid,
  input  logic                row_ready,
  output logic [Y_W-1:0]      row_y,
  output logic [TILE_W-1:0]   row_mask,
  output logic                row_last,
  output logic                tile_rejected
);

  localparam logic [Y_W-1:0] LAST_Y = Y_W'(TILE_H - 1);

  walk_state_e state_q, state_d;

  logic signed [ACC_W-1:0] aIn [3];
  logic signed [ACC_W-1:0] bIn [3];
  logic signed [ACC_W-1:0] eIn [3];
  logic signed [ACC_W-1:0] a_q [3];
  logic signed [ACC_W-1:0] b_q [3];
  logic signed [ACC_W-1:0] r_q [3];
  logic [Y_W-1:0]          y_q;
  logic [TILE_W-1:0]       neg [3];
  logic                    accept;
  logic                    rowFire;
  logic                    lastRow;
  logic                    rejectNow;

  // Descriptor inputs widened to accumulator width once, up front.
  always_comb begin
    aIn[0] = sext(A0);
    aIn[1] = sext(A1);
    aIn[2] = sext(A2);
    bIn[0] = sext(B0);
    bIn[1] = sext(B1);
    bIn[2] = sext(B2);
    eIn[0] = sext(E0_init);
    eIn[1] = sext(E1_init);
    eIn[2] = sext(E2_init);
  end

  assign accept  = valid_in && ready_in;
  assign rowFire = row_valid && row_ready;
  assign lastRow = (y_q == LAST_Y);

`ifdef TILE_COV_EARLY_REJECT_EN
  localparam logic signed [ACC_W-1:0] XSPAN = ACC_W'(TILE_W - 1);
  localparam logic signed [ACC_W-1:0] YSPAN = ACC_W'(TILE_H - 1);

  logic signed [ACC_W-1:0] cX, cY, cXY;
  logic                    rej_q;

  // An edge functions is linear, so if it is negative at all four corners
  // it is negative over the whole tile and no pixel can be covered.
  always_comb begin
    rejectNow = 1'b0;
    cX        = '0;
    cY        = '0;
    cXY       = '0;
    for (int k = 0; k < 3; k++) begin
      cX  = eIn[k] + XSPAN * aIn[k];
      cY  = eIn[k] + YSPAN * bIn[k];
      cXY = cX + YSPAN * bIn[k];
      if (eIn[k][ACC_W-1] && cX[ACC_W-1] && cY[ACC_W-1] && cXY[ACC_W-1]) begin
        rejectNow = 1'b1;
      end
    end
  end

  // The reject pulse is registered so it appears in the cycle after accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rej_q <= 1'b0;
    end else begin
      rej_q <= accept && rejectNow;
    end
  end
`else
  assign rejectNow = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a rejected tile never leaves IDLE; the walk ends on the
  // handshake of the last row.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && !rejectNow) state_d = WALK;
      WALK: if (rowFire && lastRow) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs. ready_in is masked by rst so nothing is accepted during reset;
  // the mask is forced to zero whenever no row is being presented.
  always_comb begin
    ready_in  = (state_q == IDLE) && !rst;
    row_valid = (state_q == WALK);
    row_y     = y_q;
    row_last  = row_valid && lastRow;
    row_mask  = row_valid ? ~(neg[0] | neg[1] | neg[2]) : '0;
`ifdef TILE_COV_EARLY_REJECT_EN
    tile_rejected = rej_q;
`else
    tile_rejected = 1'b0;
`endif
  end

  // Row datapath. Accumulators load E_init on accept and step by B on each
  // row handshake; a stall leaves them (and therefore the mask) untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        r_q[k] <= '0;
      end
      y_q <= '0;
    end else if (accept) begin
      for (int k = 0; k < 3; k++) begin
        a_q[k] <= aIn[k];
        b_q[k] <= bIn[k];
        r_q[k] <= eIn[k];
      end
      y_q <= '0;
    end else if (rowFire) begin
      for (int k = 0; k < 3; k++) begin
        r_q[k] <= r_q[k] + b_q[k];
      end
      y_q <= lastRow ? '0 : y_q + Y_W'(1);
    end
  end

  for (genvar k = 0; k < 3; k++) begin : g_edge
    edge_row_eval u_eval (
      .r_i   (r_q[k]),
      .a_i   (a_q[k]),
      .neg_o (neg[k])
    );
  end

endmodule
